nx_fifo_wm: RTL and testbench
=============================

Name: nx_fifo_wm

Overview:
Parametrised synchronous FIFO; next generation of the standard nx_library FIFO. Adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, and a sticky high-watermark counter for buffer sizing in the compression/crypto datapaths. Single clock domain. Drop-in for existing FIFO users: same core handshake, flags and zero-masked read data.

Parameters:
DEPTH, 4, number of entries; any integer >= 2 (power of two not required)
WIDTH, 263, data width in bits; >= 1
DATA_RESET, 1, 1 = storage array cleared to 0 by rst_n; 0 = storage not reset
AFULL_THRESH, DEPTH-1, almost_full asserts when used_slots >= AFULL_THRESH; legal range 1..DEPTH
AEMPTY_THRESH, 1, almost_empty asserts when used_slots <= AEMPTY_THRESH; legal range 0..DEPTH-1
Derived constant: CW = $clog2(DEPTH+1), width of all slot counts.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset; asynchronous, active-low
wen  input  1  write request
ren  input  1  read request (pops the head entry)
clear  input  1  synchronous flush
wdata  input  WIDTH  write data
rdata  output  WIDTH  head entry; all zeros when empty
empty  output  1  used_slots == 0
full  output  1  used_slots == DEPTH
almost_full  output  1  used_slots >= AFULL_THRESH
almost_empty  output  1  used_slots <= AEMPTY_THRESH
used_slots  output  CW  occupied entries
free_slots  output  CW  DEPTH - used_slots
high_watermark  output  CW  maximum used_slots since reset/clear
underflow  output  1  registered pulse: ren while empty
overflow  output  1  registered pulse: wen while full

Behaviour:
- Reset (rst_n low, async): rptr = wptr = 0; used_slots = 0; free_slots = DEPTH; empty = 1; full = 0; almost_empty = 1; almost_full = (AFULL_THRESH == 0 ? 1 : 0), effectively 0; high_watermark = 0; underflow = overflow = 0; rdata = 0. If DATA_RESET = 1, all storage entries = 0.
- Pointers wrap explicitly: when ptr == DEPTH-1, the next value is 0. Do not rely on modulo-2^n wrap.
- Write accepted iff wen && !full && !clear. Data lands at wptr. It is visible on rdata the cycle after the write, when empty deasserts.
- A write while full is dropped even if ren is high in the same cycle. In that case the read still pops, and overflow pulses.
- Read accepted iff ren && !empty && !clear. rptr advances. rdata is combinational from storage[rptr], masked to zero when empty. There is no read latency.
- wen && ren both accepted in the same cycle: used_slots is unchanged and both pointers advance.
- When empty with wen && ren: the write is accepted, the read is rejected, underflow pulses, and used_slots becomes 1. There is no bypass.
- underflow/overflow are registered 1-cycle pulses in the cycle after the offending request. Back-to-back offences give back-to-back pulses.
- clear has top priority. Next cycle: pointers = 0, used_slots = 0, high_watermark = 0, flags return to their reset values. A concurrent wen/ren is ignored and raises no underflow/overflow. Storage is not zeroed, but rdata reads zero because empty = 1.
- All status outputs (empty, full, almost_*, used/free) derive from the registered used_slots count, so they update in the cycle after the causing event.
- high_watermark <= max(high_watermark, next used_slots) every cycle. It never decreases except on clear or reset.
- Deasserting rst_n mid-operation discards all contents. No request is honoured in the reset cycle.
- Elaboration-time checks:
  - DEPTH < 2 is a fatal error.
  - Threshold outside its legal range is a fatal error.

Decomposition:
- Package nx_fifo_wm_pkg holds:
  - the function computing CW;
  - the pointer-increment-with-wrap function, parametrised by DEPTH.
- Sub-module nx_fifo_wm_ctrl holds the pointers, count, flag pulses, thresholds and watermark. It has no data path and is reusable by wide or RAM-backed variants.
- The top level holds the storage array, the write port and the zero-masked rdata mux.

Test Plan:
- DEPTH=5, WIDTH=8: write 0x11..0x55 on consecutive cycles -> full=1 after the 5th write; used_slots=5; free_slots=0; almost_full=1 from used_slots=4; high_watermark=5.
- DEPTH=5: fill to 5, pop 3, write 3 more (0xA1..0xA3), then drain -> read order 0x44,0x55,0xA1,0xA2,0xA3; wptr wraps 4->0 with no lost or duplicated entry.
- Full FIFO, wen=1 and ren=1 in the same cycle -> head popped, wdata dropped, overflow=1 for exactly one cycle, used_slots=4.
- Empty FIFO, wen=1 and ren=1 with wdata=0x7E -> underflow=1 for one cycle, used_slots=1, rdata=0x7E next cycle. While empty, rdata=0.
- 3 entries held, high_watermark=3, then clear=1 together with wen=1 -> next cycle empty=1, used_slots=0, high_watermark=0, rdata=0, no overflow/underflow pulse.
- Assert rst_n low asynchronously mid-burst -> all outputs reach reset values without a clock edge. With DATA_RESET=1, a subsequent single write/read returns only the new data.

Source files
------------

// File: rtl/nx_fifo_wm_pkg.sv
// Shared helpers for the nx_fifo_wm family: slot-count width and wrapping pointer step.
package nx_fifo_wm_pkg;

    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-two depths never alias
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/nx_fifo_wm_ctrl.sv
// FIFO control: pointers, occupancy, threshold flags, error pulses and sticky high watermark.
module nx_fifo_wm_ctrl
    import nx_fifo_wm_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    localparam int CW           = calc_cw(DEPTH),
    localparam int PW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen,
    input  logic          ren,
    input  logic          clear,
    output logic          wr_acc,
    output logic [PW-1:0] wptr,
    output logic [PW-1:0] rptr,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] used_slots,
    output logic [CW-1:0] free_slots,
    output logic [CW-1:0] high_watermark,
    output logic          underflow,
    output logic          overflow
);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "nx_fifo_wm: DEPTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $fatal(1, "nx_fifo_wm: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "nx_fifo_wm: AEMPTY_THRESH out of range 0..DEPTH-1");
    end

    logic [PW-1:0] wptr_reg, rptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] hwm_reg, hwm_next;
    logic          underflow_reg, overflow_reg;
    logic          rd_acc;

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == CW'(DEPTH));
    assign wr_acc = wen && !full && !clear;
    assign rd_acc = ren && !empty && !clear;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (wr_acc && !rd_acc) begin
            count_next = count_reg + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Watermark tracks the count being loaded, so it never lags the occupancy
    always_comb begin
        hwm_next = hwm_reg;
        if (clear) begin
            hwm_next = '0;
        end else if (count_next > hwm_reg) begin
            hwm_next = count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            hwm_reg       <= '0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (clear) begin
                wptr_reg <= '0;
                rptr_reg <= '0;
            end else begin
                if (wr_acc) wptr_reg <= PW'(ptr_next(32'(wptr_reg), DEPTH));
                if (rd_acc) rptr_reg <= PW'(ptr_next(32'(rptr_reg), DEPTH));
            end
            count_reg     <= count_next;
            hwm_reg       <= hwm_next;
            underflow_reg <= ren && empty && !clear;
            overflow_reg  <= wen && full && !clear;
        end
    end

    assign wptr           = wptr_reg;
    assign rptr           = rptr_reg;
    assign used_slots     = count_reg;
    assign free_slots     = CW'(DEPTH) - count_reg;
    assign almost_full    = (count_reg >= CW'(AFULL_THRESH));
    assign almost_empty   = (count_reg <= CW'(AEMPTY_THRESH));
    assign high_watermark = hwm_reg;
    assign underflow      = underflow_reg;
    assign overflow       = overflow_reg;

endmodule

// File: rtl/nx_fifo_wm.sv
// Synchronous FIFO with arbitrary depth, programmable thresholds and high watermark; storage and read mux.
module nx_fifo_wm
    import nx_fifo_wm_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int WIDTH         = 263,
    parameter bit DATA_RESET    = 1'b1,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    localparam int CW           = calc_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic             ren,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    used_slots,
    output logic [CW-1:0]    free_slots,
    output logic [CW-1:0]    high_watermark,
    output logic             underflow,
    output logic             overflow
);

    localparam int PW = $clog2(DEPTH);

    logic             wr_acc;
    logic [PW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    nx_fifo_wm_ctrl #(
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .wen            (wen),
        .ren            (ren),
        .clear          (clear),
        .wr_acc         (wr_acc),
        .wptr           (wptr),
        .rptr           (rptr),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .used_slots     (used_slots),
        .free_slots     (free_slots),
        .high_watermark (high_watermark),
        .underflow      (underflow),
        .overflow       (overflow)
    );

    if (DATA_RESET) begin : g_mem_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (wr_acc) begin
                mem[wptr] <= wdata;
            end
        end
    end else begin : g_mem_norst
        always_ff @(posedge clk) begin
            if (wr_acc) mem[wptr] <= wdata;
        end
    end

    // Masking hides stale storage after clear or when the array is not reset
    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: tb/tb_nx_fifo_wm.sv
// Scoreboard bench for nx_fifo_wm (DEPTH=5, WIDTH=8): directed stimulus, decoupled read monitor.
module tb_nx_fifo_wm;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wen = 1'b0, ren = 1'b0, clear = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH-1:0] rdata;
    logic             empty, full, almost_full, almost_empty, underflow, overflow;
    logic [CW-1:0]    used_slots, free_slots, high_watermark;

    int nvec = 0;
    int nerr = 0;
    int mcount = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    nx_fifo_wm #(
        .DEPTH (DEPTH), .WIDTH (WIDTH), .DATA_RESET (1'b1),
        .AFULL_THRESH (DEPTH - 1), .AEMPTY_THRESH (1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .wen (wen), .ren (ren), .clear (clear),
        .wdata (wdata), .rdata (rdata), .empty (empty), .full (full),
        .almost_full (almost_full), .almost_empty (almost_empty),
        .used_slots (used_slots), .free_slots (free_slots),
        .high_watermark (high_watermark), .underflow (underflow), .overflow (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // One clock of stimulus; the scoreboard entry is pushed as the request is issued
    task automatic cyc(input logic w, input logic r, input logic c, input logic [WIDTH-1:0] d);
        wen = w; ren = r; clear = c; wdata = d;
        if (c) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (w && mcount < DEPTH) begin
                exp_q.push_back(d);
                mcount++;
            end
            if (r && mcount > 0 && !(w && mcount == 1 && exp_q.size() == 1 && mcount_was_zero(w, r))) mcount--;
        end
        @(posedge clk); #1;
        wen = 1'b0; ren = 1'b0; clear = 1'b0;
        chk("used_slots", 32'(used_slots), 32'(mcount));
    endtask

    // Tracks whether the FIFO was empty before this cycle's write, since a read cannot pop then
    logic was_empty;
    function automatic bit mcount_was_zero(input logic w, input logic r);
        return was_empty && w && r;
    endfunction

    always @(posedge clk) was_empty <= (mcount == 0);

    // Monitor: the DUT presents a word whenever a read is accepted
    always @(negedge clk) begin
        if (rst_n && !clear) begin
            if (ren && !empty) begin
                if (exp_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL pop_underrun: got 0x%0h expected none", rdata);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    chk("rdata_pop", 32'(rdata), 32'(e));
                end
            end else if (empty) begin
                chk("rdata_empty_zero", 32'(rdata), 32'h0);
            end
        end
    end

    initial begin
        was_empty = 1'b1;
        #3;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_used", 32'(used_slots), 0);
        chk("rst_free", 32'(free_slots), 5);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_hwm", 32'(high_watermark), 0);
        chk("rst_uf_of", 32'({underflow, overflow}), 0);
        chk("rst_rdata", 32'(rdata), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill 0x11..0x55
        cyc(1, 0, 0, 8'h11);
        chk("aempty_at1", 32'(almost_empty), 1);
        chk("rdata_after_write", 32'(rdata), 32'h11);
        cyc(1, 0, 0, 8'h22);
        chk("aempty_at2", 32'(almost_empty), 0);
        cyc(1, 0, 0, 8'h33);
        chk("afull_at3", 32'(almost_full), 0);
        cyc(1, 0, 0, 8'h44);
        chk("afull_at4", 32'(almost_full), 1);
        chk("full_at4", 32'(full), 0);
        cyc(1, 0, 0, 8'h55);
        chk("full_at5", 32'(full), 1);
        chk("free_at5", 32'(free_slots), 0);
        chk("hwm_at5", 32'(high_watermark), 5);
        chk("of_none", 32'(overflow), 0);

        // Pop 3, refill across the wrap
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        chk("free_at2", 32'(free_slots), 3);
        chk("hwm_sticky", 32'(high_watermark), 5);
        cyc(1, 0, 0, 8'hA1);
        cyc(1, 0, 0, 8'hA2);
        cyc(1, 0, 0, 8'hA3);
        chk("full_again", 32'(full), 1);

        // Full with wen+ren: pop head 0x44, drop 0xEE, overflow pulse
        cyc(1, 1, 0, 8'hEE);
        chk("of_pulse", 32'(overflow), 1);
        chk("full_after_of", 32'(full), 0);
        cyc(0, 0, 0, 8'h00);
        chk("of_one_cycle", 32'(overflow), 0);

        // Drain 0x55,0xA1,0xA2,0xA3
        repeat (4) cyc(0, 1, 0, 8'h00);
        chk("empty_drained", 32'(empty), 1);
        cyc(0, 1, 0, 8'h00);
        chk("uf_pulse", 32'(underflow), 1);
        cyc(0, 1, 0, 8'h00);
        chk("uf_back_to_back", 32'(underflow), 1);
        cyc(0, 0, 0, 8'h00);
        chk("uf_cleared", 32'(underflow), 0);

        // Clear resets the watermark
        cyc(0, 0, 1, 8'h00);
        chk("hwm_clear", 32'(high_watermark), 0);

        // Empty with wen+ren: write only, underflow
        cyc(1, 1, 0, 8'h7E);
        chk("uf_empty_wr", 32'(underflow), 1);
        chk("rdata_7e", 32'(rdata), 32'h7E);
        chk("hwm_1", 32'(high_watermark), 1);
        cyc(1, 0, 0, 8'h01);
        cyc(1, 0, 0, 8'h02);
        chk("hwm_3", 32'(high_watermark), 3);
        chk("uf_gone", 32'(underflow), 0);

        // Clear with concurrent wen
        cyc(1, 0, 1, 8'h99);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_hwm", 32'(high_watermark), 0);
        chk("clr_rdata", 32'(rdata), 0);
        chk("clr_uf_of", 32'({underflow, overflow}), 0);
        chk("clr_aempty", 32'(almost_empty), 1);

        // Asynchronous reset mid-burst
        cyc(1, 0, 0, 8'h31);
        cyc(1, 0, 0, 8'h32);
        cyc(1, 0, 0, 8'h33);
        #1 rst_n = 1'b0;
        exp_q.delete();
        mcount = 0;
        #1;
        chk("arst_used", 32'(used_slots), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_hwm", 32'(high_watermark), 0);
        chk("arst_free", 32'(free_slots), 5);
        chk("arst_rdata", 32'(rdata), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 0, 0, 8'h9C);
        chk("post_rst_rdata", 32'(rdata), 32'h9C);
        cyc(0, 1, 0, 8'h00);
        chk("post_rst_empty", 32'(empty), 1);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
